// File: rtl/fp4_fft_input_loader_if.sv
// ---------------------------------------------------------------------------
// fp4_fft_input_loader_if
//   Valid/ready sample stream feeding the FP4 FFT input loader.
//
//   Signals
//     s_valid  producer has a sample on s_data
//     s_ready  consumer can take a sample this cycle
//     s_data   packed FP4 complex sample (real [7:4], imag [3:0] for DATA_W=8)
//
//   Modports
//     master   sample producer (drives s_valid/s_data, observes s_ready)
//     slave    the loader     (observes s_valid/s_data, drives s_ready)
// ---------------------------------------------------------------------------
interface fp4_fft_input_loader_if #(
  parameter int DATA_W = 8
);
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data;

  modport master (
    output s_valid,
    output s_data,
    input  s_ready
  );

  modport slave (
    input  s_valid,
    input  s_data,
    output s_ready
  );
endinterface

// File: rtl/fp4_fft_input_loader.sv
// ---------------------------------------------------------------------------
// fp4_fft_input_loader
//   Front end of the ping-pong FP4 FFT sample memory. Takes a valid/ready
//   stream of complex FP4 samples, groups them into N-point frames and writes
//   each sample into the bank currently being filled. Once a frame is full
//   and the FFT core is idle, bank_sel flips and frame_start pulses so the
//   core can start on the freshly written bank.
//
//   Build option
//     FFT_INPUT_BITREV_EN  defined   : write address = bit-reversed sample
//                                      index (DIT input ordering)
//                          undefined : write address = sample index
//                                      (natural order, core reorders)
//
//   Ports
//     clk          system clock, rising edge
//     rst          asynchronous reset, active low
//     s            sample stream (slave side: s_valid, s_ready, s_data)
//     wr_en_1      memory write enable            (registered)
//     wr_addr_1    memory write address           (registered)
//     wr_data_1    memory write data              (registered)
//     bank_sel     ping-pong select; 0 = core reads bank0, loader fills bank1
//     frame_start  one-cycle pulse: new frame ready in the read bank
//     proc_done    one-cycle pulse from core: current frame finished
//     fill_cnt     samples written into the filling bank (0..N)
// ---------------------------------------------------------------------------
module fp4_fft_input_loader #(
  parameter int N      = 32,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  fp4_fft_input_loader_if.slave s,
  output logic                wr_en_1,
  output logic [ADDR_W-1:0]   wr_addr_1,
  output logic [DATA_W-1:0]   wr_data_1,
  output logic                bank_sel,
  output logic                frame_start,
  input  logic                proc_done,
  output logic [ADDR_W:0]     fill_cnt
);

  localparam logic [ADDR_W-1:0] IDX_LAST = ADDR_W'(N - 1);
  localparam logic [ADDR_W:0]   FILL_MAX = (ADDR_W + 1)'(N);

  typedef enum logic [1:0] {
    FILL      = 2'd0,
    WAIT_SWAP = 2'd1,
    SWAP      = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] idx;
  logic [ADDR_W-1:0] idx_nxt;
  logic [ADDR_W:0]   fill_nxt;
  logic              core_busy;
  logic              core_busy_nxt;
  logic              ready;
  logic              accept;
  logic              swap_fire;

  // Sample index -> memory address.
  function automatic logic [ADDR_W-1:0] map_addr(input logic [ADDR_W-1:0] i);
    logic [ADDR_W-1:0] r;
    r = i;
`ifdef FFT_INPUT_BITREV_EN
    for (int b = 0; b < ADDR_W; b++) begin
      r[b] = i[ADDR_W-1-b];
    end
`endif
    return r;
  endfunction

  // Ready depends on state only, so the producer never sees a comb path
  // from its own s_valid back to s_ready.
  assign ready     = (state == FILL);
  assign s.s_ready = ready;
  assign accept    = s.s_valid & ready;

  // ---- next-state / control ----
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    fill_nxt  = fill_cnt;
    swap_fire = 1'b0;
    case (state)
      FILL: begin
        if (accept) begin
          if (idx == IDX_LAST) begin
            idx_nxt   = '0;
            fill_nxt  = FILL_MAX;
            state_nxt = WAIT_SWAP;
          end else begin
            idx_nxt  = idx + 1'b1;
            fill_nxt = fill_cnt + 1'b1;
          end
        end
      end
      WAIT_SWAP: begin
        // A proc_done arriving this cycle frees the core just in time.
        if (!core_busy || proc_done) begin
          state_nxt = SWAP;
        end
      end
      SWAP: begin
        swap_fire = 1'b1;
        fill_nxt  = '0;
        state_nxt = FILL;
      end
      default: begin
        state_nxt = FILL;
        idx_nxt   = '0;
        fill_nxt  = '0;
      end
    endcase

    // Handing a frame to the core outranks a concurrent proc_done.
    core_busy_nxt = core_busy;
    if (swap_fire) begin
      core_busy_nxt = 1'b1;
    end else if (proc_done) begin
      core_busy_nxt = 1'b0;
    end
  end

  // ---- state register ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= FILL;
    end else begin
      state <= state_nxt;
    end
  end

  // ---- frame bookkeeping and bank handover ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx         <= '0;
      fill_cnt    <= '0;
      core_busy   <= 1'b0;
      bank_sel    <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      idx         <= idx_nxt;
      fill_cnt    <= fill_nxt;
      core_busy   <= core_busy_nxt;
      bank_sel    <= bank_sel ^ swap_fire;
      frame_start <= swap_fire;
    end
  end

  // ---- memory write port (one cycle after accept) ----
  // The last sample of a frame is written during the first WAIT_SWAP cycle,
  // before bank_sel can flip, so it lands in the bank it belongs to.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_en_1   <= 1'b0;
      wr_addr_1 <= '0;
      wr_data_1 <= '0;
    end else begin
      wr_en_1 <= accept;
      if (accept) begin
        wr_addr_1 <= map_addr(idx);
        wr_data_1 <= s.s_data;
      end
    end
  end

endmodule

// File: tb/tb_fp4_fft_input_loader.sv
`timescale 1ns/1ps
module tb_fp4_fft_input_loader;
  localparam int N      = 32;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fp4_fft_input_loader_if #(.DATA_W(DATA_W)) sif ();

  logic              wr_en_1;
  logic [ADDR_W-1:0] wr_addr_1;
  logic [DATA_W-1:0] wr_data_1;
  logic              bank_sel;
  logic              frame_start;
  logic              proc_done;
  logic [ADDR_W:0]   fill_cnt;

  fp4_fft_input_loader #(.N(N), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .s           (sif),
    .wr_en_1     (wr_en_1),
    .wr_addr_1   (wr_addr_1),
    .wr_data_1   (wr_data_1),
    .bank_sel    (bank_sel),
    .frame_start (frame_start),
    .proc_done   (proc_done),
    .fill_cnt    (fill_cnt)
  );

  // Observed outputs packed as {s_ready, wr_en, addr[4:0], data[7:0], bank, fs, fill[5:0]}
  typedef struct {
    logic        v;
    logic [7:0]  d;
    logic        pd;
    logic [22:0] exp;
    string       tag;
  } vec_t;

  vec_t vq[$];
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic logic [4:0] amap(input int i);
    logic [4:0] a;
    logic [4:0] r;
    a = 5'(i);
    r = a;
`ifdef FFT_INPUT_BITREV_EN
    for (int b = 0; b < 5; b++) r[b] = a[4-b];
`endif
    return r;
  endfunction

  function automatic logic [22:0] pk(input logic rdy, input logic we, input logic [4:0] a,
                                     input logic [7:0] d, input logic b, input logic fs,
                                     input logic [5:0] f);
    return {rdy, we, a, d, b, fs, f};
  endfunction

  function automatic logic [22:0] obs();
    return {sif.s_ready, wr_en_1, wr_addr_1, wr_data_1, bank_sel, frame_start, fill_cnt};
  endfunction

  task automatic push(input logic v, input logic [7:0] d, input logic pd,
                      input logic [22:0] e, input string tag);
    vec_t x;
    x.v = v; x.d = d; x.pd = pd; x.exp = e; x.tag = tag;
    vq.push_back(x);
  endtask

  task automatic check(input string tag, input int n, input logic [22:0] act, input logic [22:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s #%0d: got {rdy,we,addr,data,bank,fs,fill}=%h want %h", tag, n, act, exp);
    end
  endtask

  initial begin
    logic [22:0] o;

    // ---------------- vector table ----------------
    // T2: first frame, core idle, swap follows 2 cycles after last accept
    for (int i = 0; i < 32; i++)
      push(1'b1, 8'(i), 1'b0, pk(i < 31, 1'b1, amap(i), 8'(i), 1'b0, 1'b0, 6'(i + 1)), "t2_fill");
    push(1'b1, 8'h20, 1'b0, pk(1'b0, 1'b0, amap(31), 8'h1F, 1'b0, 1'b0, 6'd32), "t2_wait");
    push(1'b1, 8'h20, 1'b0, pk(1'b1, 1'b0, amap(31), 8'h1F, 1'b1, 1'b1, 6'd0), "t2_swap");
    // T3: second frame while core busy, held until proc_done
    for (int i = 0; i < 32; i++)
      push(1'b1, 8'(32 + i), 1'b0, pk(i < 31, 1'b1, amap(i), 8'(32 + i), 1'b1, 1'b0, 6'(i + 1)), "t3_fill");
    for (int i = 0; i < 10; i++)
      push(1'b1, 8'h40, 1'b0, pk(1'b0, 1'b0, amap(31), 8'h3F, 1'b1, 1'b0, 6'd32), "t3_hold");
    push(1'b1, 8'h40, 1'b1, pk(1'b0, 1'b0, amap(31), 8'h3F, 1'b1, 1'b0, 6'd32), "t3_done");
    push(1'b1, 8'h40, 1'b0, pk(1'b1, 1'b0, amap(31), 8'h3F, 1'b0, 1'b1, 6'd0), "t3_swap");
    // T4: gapped input 1,0,1,0
    for (int j = 0; j < 64; j++) begin
      int k;
      k = j / 2;
      if (j % 2 == 0)
        push(1'b1, 8'(64 + k), 1'b0, pk(k < 31, 1'b1, amap(k), 8'(64 + k), 1'b0, 1'b0, 6'(k + 1)), "t4_acc");
      else
        push(1'b0, 8'hEE, 1'b0, pk(k < 31, 1'b0, amap(k), 8'(64 + k), 1'b0, 1'b0, 6'(k + 1)), "t4_gap");
    end
    for (int i = 0; i < 3; i++)
      push(1'b0, 8'h00, 1'b0, pk(1'b0, 1'b0, amap(31), 8'h5F, 1'b0, 1'b0, 6'd32), "t4_hold");
    // T6: proc_done releases the wait, then again on the frame_start edge
    push(1'b0, 8'h00, 1'b1, pk(1'b0, 1'b0, amap(31), 8'h5F, 1'b0, 1'b0, 6'd32), "t6_done");
    push(1'b0, 8'h00, 1'b1, pk(1'b1, 1'b0, amap(31), 8'h5F, 1'b1, 1'b1, 6'd0), "t6_swap_pd");
    // core must still be busy: frame 4 waits
    for (int i = 0; i < 32; i++)
      push(1'b1, 8'(96 + i), 1'b0, pk(i < 31, 1'b1, amap(i), 8'(96 + i), 1'b1, 1'b0, 6'(i + 1)), "t6_fill");
    for (int i = 0; i < 4; i++)
      push(1'b0, 8'h00, 1'b0, pk(1'b0, 1'b0, amap(31), 8'h7F, 1'b1, 1'b0, 6'd32), "t6_busy_hold");
    push(1'b0, 8'h00, 1'b1, pk(1'b0, 1'b0, amap(31), 8'h7F, 1'b1, 1'b0, 6'd32), "t6_done2");
    push(1'b0, 8'h00, 1'b0, pk(1'b1, 1'b0, amap(31), 8'h7F, 1'b0, 1'b1, 6'd0), "t6_swap2");
    // clear busy, then a proc_done while idle must do nothing
    push(1'b0, 8'h00, 1'b1, pk(1'b1, 1'b0, amap(31), 8'h7F, 1'b0, 1'b0, 6'd0), "t6_clear");
    push(1'b0, 8'h00, 1'b1, pk(1'b1, 1'b0, amap(31), 8'h7F, 1'b0, 1'b0, 6'd0), "t6_idle_pd");
    push(1'b0, 8'h00, 1'b0, pk(1'b1, 1'b0, amap(31), 8'h7F, 1'b0, 1'b0, 6'd0), "t6_idle");
    // frame 5 with core idle swaps without waiting
    for (int i = 0; i < 32; i++)
      push(1'b1, 8'(128 + i), 1'b0, pk(i < 31, 1'b1, amap(i), 8'(128 + i), 1'b0, 1'b0, 6'(i + 1)), "t6_fill5");
    push(1'b0, 8'h00, 1'b0, pk(1'b0, 1'b0, amap(31), 8'h9F, 1'b0, 1'b0, 6'd32), "t6_wait5");
    push(1'b0, 8'h00, 1'b0, pk(1'b1, 1'b0, amap(31), 8'h9F, 1'b1, 1'b1, 6'd0), "t6_swap5");
    // T5 prefix: 17 accepts into a partial frame (bank_sel=1)
    for (int i = 0; i < 17; i++)
      push(1'b1, 8'(192 + i), 1'b0, pk(1'b1, 1'b1, amap(i), 8'(192 + i), 1'b1, 1'b0, 6'(i + 1)), "t5_fill");

    // ---------------- T1: reset with random inputs ----------------
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sif.s_valid = 1'($urandom_range(0, 1));
      sif.s_data  = 8'($urandom);
      proc_done   = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      o = obs();
      check("t1_reset", i, {1'b0, o[21:0]}, 23'h0);
    end
    sif.s_valid = 1'b0;
    sif.s_data  = 8'h00;
    proc_done   = 1'b0;
    rst = 1'b1;
    #1;
    check("t1_release", 0, obs(), pk(1'b1, 1'b0, 5'd0, 8'h00, 1'b0, 1'b0, 6'd0));

    // ---------------- apply table ----------------
    for (int i = 0; i < vq.size(); i++) begin
      sif.s_valid = vq[i].v;
      sif.s_data  = vq[i].d;
      proc_done   = vq[i].pd;
      @(posedge clk); #1;
      check(vq[i].tag, i, obs(), vq[i].exp);
    end

    // ---------------- T5: asynchronous reset mid-frame ----------------
    sif.s_valid = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    check("t5_in_reset", 0, obs(), pk(1'b1, 1'b0, 5'd0, 8'h00, 1'b0, 1'b0, 6'd0));
    #1;
    rst = 1'b1;
    sif.s_valid = 1'b1;
    sif.s_data  = 8'hA5;
    @(posedge clk); #1;
    check("t5_first_write", 0, obs(), pk(1'b1, 1'b1, amap(0), 8'hA5, 1'b0, 1'b0, 6'd1));
    sif.s_valid = 1'b1;
    sif.s_data  = 8'h5A;
    @(posedge clk); #1;
    check("t5_second_write", 0, obs(), pk(1'b1, 1'b1, amap(1), 8'h5A, 1'b0, 1'b0, 6'd2));
    sif.s_valid = 1'b0;
    @(posedge clk); #1;
    check("t5_idle", 0, obs(), pk(1'b1, 1'b0, amap(1), 8'h5A, 1'b0, 1'b0, 6'd2));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
